dr_ald_16by8_pipe: RTL and testbench

Pipelined signed approximate logarithmic divider: the divide-direction counterpart of the 8-bit dynamic-range approximate log multiplier. It computes a 16-bit signed dividend over an 8-bit signed divisor using Mitchell-style log subtraction with dynamic truncation. It sits on a valid/ready stream alongside the multiplier in the approximate-arithmetic datapath. It has 3-cycle latency, accepts one operation per cycle, and supports full backpressure.

---
 rtl/alm_pkg.sv | 44 ++++
 rtl/alm_lod.sv | 17 +
 rtl/dr_ald_16by8_pipe.sv | 116 +++++++++++
 tb/tb_dr_ald_16by8_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alm_pkg.sv
// Shared types, constants and helpers for the approximate log multiply/divide datapath.
package alm_pkg;

    localparam int unsigned TRUNC_WIDTH_DEF = 6;
    localparam int unsigned FRAC_W          = 8;
    localparam int unsigned K_W             = 6;

    localparam logic signed [15:0] Q_MAX = 16'sd32767;
    localparam logic signed [15:0] Q_MIN = 16'sh8000;

    typedef struct packed {
        logic              sign_q;
        logic              a_zero;
        logic              b_zero;
        logic              a_neg;
        logic [3:0]        k_a;
        logic [2:0]        k_b;
        logic [FRAC_W-1:0] x_a;
        logic [FRAC_W-1:0] x_b;
    } s1_t;

    typedef struct packed {
        logic                  sign_q;
        logic                  a_zero;
        logic                  b_zero;
        logic                  a_neg;
        logic signed [K_W-1:0] k;
        logic [FRAC_W-1:0]     frac;
    } s2_t;

    typedef struct packed {
        logic [15:0] q;
        logic        div0;
        logic        sat;
    } s3_t;

    // Keep the t-1 bits under the leading one (at bit 15) and append a 1 as rounding LSB.
    function automatic logic [FRAC_W-1:0] trunc_frac(input logic [15:0] norm, input int unsigned t);
        logic [14:0] below;
        below = norm[14:0] >> (16 - t);
        return FRAC_W'({below, 1'b1});
    endfunction

endpackage

// File: rtl/alm_lod.sv
// Leading-one detector: position of the most significant set bit (0 when vec is zero).
module alm_lod #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0]         vec,
    output logic [$clog2(W)-1:0] pos_c
);
    localparam int unsigned PW = $clog2(W);

    always_comb begin
        pos_c = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) pos_c = PW'(i);
        end
    end

endmodule

// File: rtl/dr_ald_16by8_pipe.sv
// 3-stage signed Mitchell-style approximate divider, 16-bit dividend over 8-bit divisor,
// on a valid/ready stream with a single global advance enable.
module dr_ald_16by8_pipe
    import alm_pkg::*;
#(
    parameter int unsigned TRUNC_WIDTH = TRUNC_WIDTH_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_a,
    input  logic [7:0]  i_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_q,
    output logic        o_div0,
    output logic        o_sat
);
    localparam int unsigned T         = TRUNC_WIDTH;
    localparam logic [8:0]  FRAC_MASK = 9'((1 << T) - 1);

    logic        en;
    logic        v1, v2, v3;
    s1_t         s1_d, s1_q;
    s2_t         s2_d, s2_q;
    s3_t         s3_d, s3_q;

    logic [15:0] mag_a, norm_a;
    logic [7:0]  mag_b, norm_b;
    logic [3:0]  k_a;
    logic [2:0]  k_b;
    logic [8:0]  diff;
    logic [31:0] m, mag;

    assign en      = !v3 || i_ready;
    assign o_ready = en;
    assign o_valid = v3;
    assign o_q     = s3_q.q;
    assign o_div0  = s3_q.div0;
    assign o_sat   = s3_q.sat;

    // S1: magnitudes, leading-one positions, normalized truncated mantissas
    assign mag_a  = i_a[15] ? 16'(~i_a + 16'd1) : i_a;
    assign mag_b  = i_b[7]  ? 8'(~i_b + 8'd1)   : i_b;
    assign norm_a = mag_a << (4'd15 - k_a);
    assign norm_b = mag_b << (3'd7 - k_b);

    alm_lod #(.W(16)) u_lod_a (.vec(mag_a), .pos_c(k_a));
    alm_lod #(.W(8))  u_lod_b (.vec(mag_b), .pos_c(k_b));

    always_comb begin
        s1_d        = '0;
        s1_d.sign_q = i_a[15] ^ i_b[7];
        s1_d.a_zero = (i_a == 16'd0);
        s1_d.b_zero = (i_b == 8'd0);
        s1_d.a_neg  = i_a[15];
        s1_d.k_a    = k_a;
        s1_d.k_b    = k_b;
        s1_d.x_a    = trunc_frac(norm_a, T);
        s1_d.x_b    = trunc_frac({norm_b, 8'h00}, T);
    end

    // S2: mantissa subtract; a borrow leaves frac already wrapped by 2^T
    assign diff = {1'b0, s1_q.x_a} - {1'b0, s1_q.x_b};

    always_comb begin
        s2_d        = '0;
        s2_d.sign_q = s1_q.sign_q;
        s2_d.a_zero = s1_q.a_zero;
        s2_d.b_zero = s1_q.b_zero;
        s2_d.a_neg  = s1_q.a_neg;
        s2_d.k      = K_W'(s1_q.k_a) - K_W'(s1_q.k_b) - K_W'(diff[T]);
        s2_d.frac   = FRAC_W'(diff & FRAC_MASK);
    end

    // S3: antilog as (1.frac << k) with T fraction bits dropped, then sign and saturate
    assign m = 32'(s2_q.frac) | (32'd1 << T);

    always_comb begin
        mag  = '0;
        s3_d = '0;
        if (s2_q.k >= 0) mag = (m << s2_q.k[3:0]) >> T;
        if (s2_q.b_zero) begin
            s3_d.div0 = 1'b1;
            if (!s2_q.a_zero) s3_d.q = s2_q.a_neg ? Q_MIN : Q_MAX;
        end else if (s2_q.a_zero) begin
            s3_d.q = 16'd0;
        end else if (!s2_q.sign_q && mag > 32'd32767) begin
            s3_d.q   = Q_MAX;
            s3_d.sat = 1'b1;
        end else if (s2_q.sign_q && mag > 32'd32768) begin
            s3_d.q   = Q_MIN;
            s3_d.sat = 1'b1;
        end else begin
            s3_d.q = s2_q.sign_q ? 16'(32'd0 - mag) : 16'(mag);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s3_q <= '0;
        end else if (en) begin
            v1   <= i_valid;
            v2   <= v1;
            v3   <= v2;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: tb/tb_dr_ald_16by8_pipe.sv
// Self-checking bench for dr_ald_16by8_pipe against an arithmetic Mitchell divider model.
module tb_dr_ald_16by8_pipe;
    localparam int T = 6;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_a;
    logic [7:0]  i_b;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_q;
    logic        o_div0;
    logic        o_sat;

    int tests_run    = 0;
    int tests_failed = 0;

    dr_ald_16by8_pipe #(.TRUNC_WIDTH(T)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_a    (i_a),
        .i_b    (i_b),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_q    (o_q),
        .o_div0 (o_div0),
        .o_sat  (o_sat)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: floor-log2, truncated mantissa in plain integers, exponent/mantissa difference, antilog.
    function automatic void golden(input logic [15:0] a, input logic [7:0] b,
                                   output logic [15:0] q, output logic div0, output logic sat);
        int sa, sb, ma, mb, ka, kb, xa, xb, d, k;
        longint mag;
        bit neg;
        q = 16'd0; div0 = 1'b0; sat = 1'b0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            div0 = 1'b1;
            if (sa > 0) q = 16'h7fff;
            else if (sa < 0) q = 16'h8000;
            return;
        end
        if (sa == 0) return;
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        ka = 0; while ((ma >> (ka + 1)) != 0) ka++;
        kb = 0; while ((mb >> (kb + 1)) != 0) kb++;
        xa = 2 * (((ma << (T - 1)) >> ka) % (1 << (T - 1))) + 1;
        xb = 2 * (((mb << (T - 1)) >> kb) % (1 << (T - 1))) + 1;
        d = xa - xb;
        k = ka - kb;
        if (d < 0) begin
            k = k - 1;
            d = d + (1 << T);
        end
        mag = (k < 0) ? 64'sd0 : ((longint'((1 << T) + d)) << k) >> T;
        neg = (sa < 0) != (sb < 0);
        if (!neg && mag > 32767) begin
            q = 16'h7fff; sat = 1'b1;
        end else if (neg && mag > 32768) begin
            q = 16'h8000; sat = 1'b1;
        end else begin
            q = neg ? 16'(-mag) : 16'(mag);
        end
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            i_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if ({o_valid, o_q, o_div0, o_sat} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b q=%h div0=%b sat=%b, expected all zero",
                     o_valid, o_q, o_div0, o_sat);
        end
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", o_ready);
        end
    endtask

    // One isolated operation: checks latency, quotient, flags against a spec constant and the model
    task automatic check_single(input logic [15:0] a, input logic [7:0] b, input logic [15:0] exp_q,
                                input logic exp_div0, input logic exp_sat, input string name);
        int lat;
        logic [15:0] gq;
        logic gd, gs;
        golden(a, b, gq, gd, gs);
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_a = a; i_b = b; i_ready = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ready: got %b expected 1", name, o_ready);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge i_clk);
            if (o_valid === 1'b1 || lat >= 8) break;
            @(posedge i_clk);
            lat++;
        end
        tests_run++;
        if (o_valid !== 1'b1 || lat != 3) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d cycles (valid=%b) expected 3", name, lat, o_valid);
        end
        tests_run++;
        if ({o_q, o_div0, o_sat} !== {exp_q, exp_div0, exp_sat}) begin
            tests_failed++;
            $display("FAIL %s: got q=%0d div0=%b sat=%b expected q=%0d div0=%b sat=%b", name,
                     $signed(o_q), o_div0, o_sat, $signed(exp_q), exp_div0, exp_sat);
        end
        tests_run++;
        if ({o_q, o_div0, o_sat} !== {gq, gd, gs}) begin
            tests_failed++;
            $display("FAIL %s_model: got q=%0d div0=%b sat=%b model q=%0d div0=%b sat=%b", name,
                     $signed(o_q), o_div0, o_sat, $signed(gq), gd, gs);
        end
    endtask

    task automatic test_basic();
        check_single(16'd64, 8'd4, 16'd16, 1'b0, 1'b0, "div_64_4");
        check_single(-16'sd100, 8'd5, -16'sd21, 1'b0, 1'b0, "div_m100_5");
        check_single(16'd96, 8'd7, 16'd14, 1'b0, 1'b0, "div_96_7_borrow");
    endtask

    task automatic test_edges();
        check_single(16'h8000, 8'hff, 16'h7fff, 1'b0, 1'b1, "edge_min_m1");
        check_single(16'h8000, 8'd1, 16'h8000, 1'b0, 1'b0, "edge_min_1");
        check_single(16'd5, 8'd100, 16'd0, 1'b0, 1'b0, "edge_k_neg");
    endtask

    task automatic test_div0();
        check_single(16'd1234, 8'd0, 16'h7fff, 1'b1, 1'b0, "div0_pos");
        check_single(-16'sd7, 8'd0, 16'h8000, 1'b1, 1'b0, "div0_neg");
        check_single(16'd0, 8'd0, 16'd0, 1'b1, 1'b0, "div0_zero");
    endtask

    // Random stream with scoreboard; optional gap check and stall-hold checks
    task automatic run_stream(input int n, input int vpct, input int rpct, input bit no_gaps,
                              input string tag);
        logic [17:0] exp_q[$];
        logic [17:0] e, held;
        logic [15:0] gq;
        logic gd, gs;
        int sent, rcv, cyc;
        bit stall;
        sent = 0; rcv = 0; cyc = 0; stall = 1'b0; held = '0;
        while (rcv < n && cyc < 3000) begin
            @(posedge i_clk); #1;
            cyc++;
            i_valid = (sent < n) && ($urandom_range(99) < vpct);
            i_a     = 16'($urandom);
            i_b     = 8'($urandom);
            i_ready = ($urandom_range(99) < rpct);
            @(negedge i_clk);
            if (stall) begin
                tests_run++;
                if (o_valid !== 1'b1 || {o_q, o_div0, o_sat} !== held) begin
                    tests_failed++;
                    $display("FAIL %s_stall_hold: got valid=%b out=%h expected valid=1 out=%h",
                             tag, o_valid, {o_q, o_div0, o_sat}, held);
                end
            end
            tests_run++;
            if (o_ready !== (!o_valid || i_ready)) begin
                tests_failed++;
                $display("FAIL %s_ready: got %b expected %b", tag, o_ready, !o_valid || i_ready);
            end
            if (no_gaps && rcv > 0 && rcv < n) begin
                tests_run++;
                if (o_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s_gap: got valid=%b after %0d results expected 1", tag, o_valid, rcv);
                end
            end
            if (o_valid === 1'b1 && i_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s_extra: got unexpected result %h expected none", tag, o_q);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_q, o_div0, o_sat} !== e) begin
                        tests_failed++;
                        $display("FAIL %s_data[%0d]: got q=%h div0=%b sat=%b expected q=%h div0=%b sat=%b",
                                 tag, rcv, o_q, o_div0, o_sat, e[17:2], e[1], e[0]);
                    end
                end
                rcv++;
            end
            stall = (o_valid === 1'b1) && !i_ready;
            held  = {o_q, o_div0, o_sat};
            if (i_valid && o_ready === 1'b1) begin
                golden(i_a, i_b, gq, gd, gs);
                exp_q.push_back({gq, gd, gs});
                sent++;
            end
        end
        tests_run++;
        if (rcv != n || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d results (%0d pending) expected %0d", tag, rcv, exp_q.size(), n);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b0; i_ready = 1'b1;
            @(negedge i_clk);
            tests_run++;
            if (o_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_drain: got valid=%b expected 0", tag, o_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_stream(20, 100, 100, 1'b1, "b2b");
    endtask

    task automatic test_backpressure();
        run_stream(60, 70, 50, 1'b0, "bp");
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b1; i_ready = 1'b1;
            i_a = 16'($urandom) | 16'd1; i_b = 8'($urandom) | 8'd1;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_ready = 1'b0; i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_ready = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if ({o_valid, o_q, o_div0, o_sat} !== 19'd0 || o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got valid=%b q=%h div0=%b sat=%b ready=%b expected zeros, ready=1",
                     o_valid, o_q, o_div0, o_sat, o_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            tests_run++;
            if (o_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_stale: got valid=%b q=%h at cycle %0d expected 0", o_valid, o_q, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        idle(4);
        test_edges();
        idle(4);
        test_div0();
        idle(4);
        test_back_to_back();
        idle(4);
        test_backpressure();
        idle(4);
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
